vx_sfu_pe_sched: RTL

Request scheduler and response arbiter for the SFU processing elements (warp-control and CSR PEs). It steers each dispatched SFU request to the PE chosen by the caller, enforces a per-PE outstanding-request credit limit, merges PE responses through a round-robin arbiter into one registered response stream, and sequences a drain/flush handshake so that SFU state changes can quiesce all PEs.

---
 rtl/vx_sfu_pe_sched_if.sv | 42 ++++
 rtl/vx_sfu_pe_sched.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/vx_sfu_pe_sched_if.sv
// Handshake bundle between the SFU dispatcher, the SFU PEs and the merged
// response consumer. The scheduler uses the slave view; its environment the master view.
interface vx_sfu_pe_sched_if #(
    parameter int unsigned PE_COUNT = 2,
    parameter int unsigned REQ_W    = 64,
    parameter int unsigned RSP_W    = 64
);
    localparam int unsigned SEL_W = $clog2(PE_COUNT);

    logic                      req_valid;
    logic [REQ_W-1:0]          req_data;
    logic [SEL_W-1:0]          req_pe_sel;
    logic                      req_ready;
    logic [PE_COUNT-1:0]       pe_req_valid;
    logic [REQ_W-1:0]          pe_req_data;
    logic [PE_COUNT-1:0]       pe_req_ready;
    logic [PE_COUNT-1:0]       pe_rsp_valid;
    logic [PE_COUNT*RSP_W-1:0] pe_rsp_data;
    logic [PE_COUNT-1:0]       pe_rsp_ready;
    logic                      rsp_valid;
    logic [RSP_W-1:0]          rsp_data;
    logic [SEL_W-1:0]          rsp_pe;
    logic                      rsp_ready;
    logic                      flush;
    logic                      flush_done;
    logic                      busy;
    logic                      err;

    modport slave (
        input  req_valid, req_data, req_pe_sel, pe_req_ready, pe_rsp_valid, pe_rsp_data,
               rsp_ready, flush,
        output req_ready, pe_req_valid, pe_req_data, pe_rsp_ready, rsp_valid, rsp_data,
               rsp_pe, flush_done, busy, err
    );

    modport master (
        output req_valid, req_data, req_pe_sel, pe_req_ready, pe_rsp_valid, pe_rsp_data,
               rsp_ready, flush,
        input  req_ready, pe_req_valid, pe_req_data, pe_rsp_ready, rsp_valid, rsp_data,
               rsp_pe, flush_done, busy, err
    );
endinterface

// File: rtl/vx_sfu_pe_sched.sv
// SFU PE scheduler: steers requests to a caller-chosen PE under a per-PE credit
// limit, merges PE responses round-robin into one registered stream, and runs a
// drain/flush handshake that waits for every PE to go quiet.
module vx_sfu_pe_sched #(
    parameter int unsigned PE_COUNT        = 2,
    parameter int unsigned REQ_W           = 64,
    parameter int unsigned RSP_W           = 64,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic             clk,
    input  logic             reset,
    vx_sfu_pe_sched_if.slave bus
);
    localparam int unsigned SEL_W = $clog2(PE_COUNT);
    localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

    typedef enum logic [1:0] {StRun, StDrain, StDone} state_e;

    state_e              r_state;
    state_e              w_state_nxt;
    logic [CNT_W-1:0]    r_cnt [PE_COUNT];
    logic [SEL_W-1:0]    r_ptr;
    logic                r_rsp_valid;
    logic [RSP_W-1:0]    r_rsp_data;
    logic [SEL_W-1:0]    r_rsp_pe;
    logic                r_err;

    logic                w_sel_ok;
    logic                w_cnt_ok;
    logic                w_sel_rdy;
    logic                w_req_ok;
    logic [PE_COUNT-1:0] w_pe_req_valid;
    logic [PE_COUNT-1:0] w_req_fire;
    logic [PE_COUNT-1:0] w_cnt_zero;
    logic [SEL_W-1:0]    w_rr_idx [PE_COUNT];
    logic                w_load;
    logic                w_found;
    logic [SEL_W-1:0]    w_gidx;
    logic [PE_COUNT-1:0] w_grant;
    logic [RSP_W-1:0]    w_gdata;
    logic                w_all_idle;
    logic                w_err_set;

    // Request steering: credit and state gate the selected PE, zero latency.
    always_comb begin
        w_sel_ok       = 32'(bus.req_pe_sel) < PE_COUNT;
        w_cnt_ok       = 1'b0;
        w_sel_rdy      = 1'b0;
        w_pe_req_valid = '0;
        for (int i = 0; i < PE_COUNT; i++) begin
            if (bus.req_pe_sel == SEL_W'(i)) begin
                w_cnt_ok  = r_cnt[i] < CNT_MAX;
                w_sel_rdy = bus.pe_req_ready[i];
            end
        end
        w_req_ok = (r_state == StRun) && w_sel_ok && w_cnt_ok;
        for (int i = 0; i < PE_COUNT; i++) begin
            w_pe_req_valid[i] = bus.req_valid && w_req_ok && (bus.req_pe_sel == SEL_W'(i));
        end
        w_req_fire = w_pe_req_valid & bus.pe_req_ready;
    end

    // Round-robin search starting at r_ptr; grant only when the output register can load.
    always_comb begin
        w_load  = !r_rsp_valid || bus.rsp_ready;
        w_found = 1'b0;
        w_gidx  = '0;
        for (int k = 0; k < PE_COUNT; k++) begin
            w_rr_idx[k] = (32'(r_ptr) + 32'(k) >= PE_COUNT) ?
                          SEL_W'(32'(r_ptr) + 32'(k) - PE_COUNT) :
                          SEL_W'(32'(r_ptr) + 32'(k));
            if (!w_found && bus.pe_rsp_valid[w_rr_idx[k]]) begin
                w_found = 1'b1;
                w_gidx  = w_rr_idx[k];
            end
        end
        w_grant = '0;
        if (w_load && w_found) begin
            w_grant[w_gidx] = 1'b1;
        end
        w_gdata = '0;
        for (int i = 0; i < PE_COUNT; i++) begin
            if (w_gidx == SEL_W'(i)) begin
                w_gdata = bus.pe_rsp_data[i*RSP_W +: RSP_W];
            end
        end
    end

    // Idle detection and protocol-error sources (bad PE index, unsolicited response).
    always_comb begin
        for (int i = 0; i < PE_COUNT; i++) begin
            w_cnt_zero[i] = (r_cnt[i] == '0);
        end
        w_all_idle = (&w_cnt_zero) && !r_rsp_valid;
        w_err_set  = (bus.req_valid && !w_sel_ok) || (|(w_grant & ~w_req_fire & w_cnt_zero));
    end

    // Per-PE outstanding counters; a response with nothing outstanding leaves 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < PE_COUNT; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < PE_COUNT; i++) begin
                if (w_req_fire[i] && !w_grant[i]) begin
                    r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                end else if (!w_req_fire[i] && w_grant[i] && !w_cnt_zero[i]) begin
                    r_cnt[i] <= r_cnt[i] - CNT_W'(1);
                end
            end
        end
    end

    // Output register, arbiter pointer and sticky error flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_pe    <= '0;
            r_ptr       <= '0;
            r_err       <= 1'b0;
        end else begin
            if (w_load && w_found) begin
                r_rsp_valid <= 1'b1;
                r_rsp_data  <= w_gdata;
                r_rsp_pe    <= w_gidx;
                r_ptr       <= (32'(w_gidx) == PE_COUNT - 1) ? '0 : w_gidx + SEL_W'(1);
            end else if (bus.rsp_ready) begin
                r_rsp_valid <= 1'b0;
            end
            if (w_err_set) begin
                r_err <= 1'b1;
            end
        end
    end

    // Flush FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= StRun;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Flush FSM next state: DRAIN waits for all PEs and the output register to empty.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            StRun:   if (bus.flush) w_state_nxt = StDrain;
            StDrain: if (w_all_idle) w_state_nxt = StDone;
            StDone:  w_state_nxt = StRun;
            default: w_state_nxt = StRun;
        endcase
    end

    assign bus.req_ready    = w_req_ok && w_sel_rdy;
    assign bus.pe_req_valid = w_pe_req_valid;
    assign bus.pe_req_data  = bus.req_data;
    assign bus.pe_rsp_ready = w_grant;
    assign bus.rsp_valid    = r_rsp_valid;
    assign bus.rsp_data     = r_rsp_data;
    assign bus.rsp_pe       = r_rsp_pe;
    assign bus.flush_done   = (r_state == StDone);
    assign bus.busy         = !w_all_idle;
    assign bus.err          = r_err;
endmodule
